interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Bus-mapped interrupt controller that collects IRQ lines from peripherals (buttons, timers, UART, ...) and presents a single prioritised interrupt to the CPU.
- Latches rising edges into pending bits and applies a per-source enable mask.
- Resolves fixed priority: lowest index wins.
- Implements a claim/complete handshake so software services one source at a time.
- Sits on the system bus beside the device bus interfaces; the CPU interrupt input connects to irq_out.

Parameters:
START_ADDR, 32'h0, base address; four 32-bit registers at START_ADDR + 4*k, k = 0..3
N_SOURCES, 8, number of IRQ inputs, 1..31

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
irq_in  input  N_SOURCES  device IRQ lines, sampled on clk
irq_out  output  1  interrupt request to CPU
addr_bus  input  32  bus address
data_bus  inout  32  bus data; driven only during a read hit, else 'z
rd_bus  input  1  bus read strobe
wr_bus  input  1  bus write strobe
data_mask_bus  input  4  byte-lane enables for writes
fc_bus  output  1  function-complete; driven only on address hit, else 'z

Behaviour:
Reset:
- One clock, synchronous active-high; all state is cleared on the clock edge where rst=1.
- On reset: enable=0, pending=0, in_service=0, prev_irq=0, bus FSM=IDLE, irq_out=0.

Edge capture:
- prev_irq <= irq_in every cycle.
- rise = irq_in & ~prev_irq sets pending bits, regardless of enable.

Priority resolution (combinational):
- cand = pending & enable.
- top = index of lowest set bit of cand; cand_valid = |cand.
- irq_out = cand_valid && (in_service == 0); registered, so it asserts 1 cycle after pending/enable settle.

Registers (word index k = addr[3:2]; hit when addr in [START_ADDR, START_ADDR+16)):
- k=0 ENABLE: R/W; bits >= N_SOURCES read 0 and ignore writes; byte-masked writes merge with the existing value.
- k=1 PENDING: R; write-1-to-clear, byte-masked.
- k=2 CLAIM: R = {cand_valid, 26'b0, top[4:0]}; write ignored.
  - Side effect, first read cycle only: if cand_valid, clear pending[top] and set in_service[top].
- k=3 COMPLETE: W data[4:0] = index; clears in_service[index]; index >= N_SOURCES ignored; reads return in_service.

Bus FSM states: IDLE, DONE.
- IDLE + read hit:
  - data_bus is driven combinationally and fc_bus=1 in the same cycle.
  - The CLAIM side effect is applied on this clock edge; go to DONE.
- IDLE + write hit: apply the write; go to DONE; fc_bus=1 from the next cycle.
- DONE:
  - fc_bus=1 while the strobe is held.
  - Return to IDLE when rd_bus and wr_bus both drop.
  - No further side effects until the FSM returns to IDLE, so a held CLAIM read claims once.

Boundary conditions:
- Simultaneous rise and W1C clear of the same bit: rise wins (bit stays set).
- Simultaneous rise and CLAIM of the same bit: pending ends set (new edge re-pends).
- A source re-pends while in service: allowed; it is delivered after COMPLETE.
- CLAIM with cand_valid=0 returns 0 with no side effect.
- Disabling a pending source hides it from cand, but the pending bit remains.
- rst during a bus transaction: FSM returns to IDLE; fc_bus reflects the new state.

Optional Feature:
INTC_NESTING_EN
- Defined:
  - irq_out = cand_valid && top < lowest set index of in_service (or in_service==0), so a higher-priority source preempts.
  - CLAIM is permitted while another source is in service.
  - COMPLETE clears only the named bit.
- Undefined:
  - No preemption; irq_out is held 0 while any in_service bit is set.
  - CLAIM reads while a source is in service return cand_valid=0 with no side effect.

Test Plan:
- Reset, enable=0x05, pulse irq_in[2] then irq_in[0] -> PENDING=0x05, irq_out=1; CLAIM reads 0x80000000; pending=0x04, in_service=0x01.
- Continuing: irq_out=0 (no nesting); write COMPLETE=0 -> irq_out=1 next cycle; CLAIM reads 0x80000002.
- Hold rd_bus on CLAIM 5 cycles with pending=0x06 -> fc_bus=1 throughout; only bit 1 claimed; PENDING afterwards=0x04.
- Same cycle: irq_in[3] rises and PENDING written 0x08 -> bit 3 remains set.
- Write ENABLE 0xFFFFFFFF with data_mask_bus=4'b0001 -> ENABLE reads 0x000000FF; then mask 4'b0010 -> unchanged.
- INTC_NESTING_EN: claim source 4, then pulse irq_in[1] -> irq_out=1; CLAIM=0x80000001; in_service=0x12; pulse irq_in[6] -> irq_out stays 0.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Bus-mapped interrupt controller. Rising edges on irq_in are latched into
// pending bits, masked by a per-source enable, and the lowest-numbered enabled
// pending source is presented to the CPU on irq_out. Software takes a source
// with a CLAIM read and releases it with a COMPLETE write.
//
// Register map (word k at START_ADDR + 4*k):
//   k=0 ENABLE    R/W, byte-masked write
//   k=1 PENDING   R, write-1-to-clear, byte-masked
//   k=2 CLAIM     R {valid, 26'b0, index[4:0]}; first read cycle claims
//   k=3 COMPLETE  W index in data[4:0]; reads return in_service
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   irq_in         device IRQ lines (edge-captured)
//   irq_out        registered interrupt request to the CPU
//   addr_bus, data_bus, rd_bus, wr_bus, data_mask_bus
//                  system bus; data_bus driven only on a read hit
//   fc_bus         function-complete, driven only on an address hit
//
// Build option:
//   INTC_NESTING_EN  when defined, a higher-priority source preempts one in
//                    service and CLAIM is allowed while sources are in service.
module interrupt_controller #(
    parameter logic [31:0] START_ADDR = 32'h0,
    parameter int unsigned N_SOURCES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SOURCES-1:0] irq_in,
    output logic                 irq_out,
    input  logic [31:0]          addr_bus,
    inout  wire  [31:0]          data_bus,
    input  logic                 rd_bus,
    input  logic                 wr_bus,
    input  logic [3:0]           data_mask_bus,
    output logic                 fc_bus
);

    typedef enum logic {StIdle, StDone} bus_state_e;

    bus_state_e           state_q;
    logic [N_SOURCES-1:0] enable_q, pending_q, in_service_q, prev_irq_q;
    logic                 irq_q;

    logic [N_SOURCES-1:0] enable_d, pending_d, in_service_d;
    logic [N_SOURCES-1:0] rise, cand, claim_set, pending_clr, svc_clr;
    logic                 cand_valid, claim_ok, irq_d;
    logic [4:0]           top;
    logic [31:0]          offset, wdata, rdata, byte_mask, en_merged;
    logic [1:0]           widx;
    logic                 hit, rd_hit, wr_hit, idle, fc_val;
    logic                 unused_offset;

    // ---------------- Address decode ----------------
    assign offset        = addr_bus - START_ADDR;
    assign hit           = (offset[31:4] == 28'd0);
    assign widx          = offset[3:2];
    assign unused_offset = ^offset[1:0];
    assign rd_hit        = hit && rd_bus;
    // A simultaneous read strobe takes precedence over a write.
    assign wr_hit        = hit && wr_bus && !rd_bus;
    assign idle          = (state_q == StIdle);
    assign wdata         = data_bus;
    assign byte_mask     = {{8{data_mask_bus[3]}}, {8{data_mask_bus[2]}},
                            {8{data_mask_bus[1]}}, {8{data_mask_bus[0]}}};

    // ---------------- Priority resolution ----------------
    assign rise       = irq_in & ~prev_irq_q;
    assign cand       = pending_q & enable_q;
    assign cand_valid = |cand;

    always_comb begin
        top = '0;
        for (int i = int'(N_SOURCES) - 1; i >= 0; i--) begin
            if (cand[i]) top = 5'(i);
        end
    end

`ifdef INTC_NESTING_EN
    logic [4:0] svc_low;

    always_comb begin
        svc_low = '0;
        for (int i = int'(N_SOURCES) - 1; i >= 0; i--) begin
            if (in_service_q[i]) svc_low = 5'(i);
        end
    end

    assign claim_ok = cand_valid;
    assign irq_d    = cand_valid && ((in_service_q == '0) || (top < svc_low));
`else
    // Without nesting nothing is delivered or claimable while a source is in service.
    assign claim_ok = cand_valid && (in_service_q == '0);
    assign irq_d    = claim_ok;
`endif

    // ---------------- Read data and handshake ----------------
    always_comb begin
        rdata = '0;
        unique case (widx)
            2'd0: rdata = 32'(enable_q);
            2'd1: rdata = 32'(pending_q);
            2'd2: rdata = claim_ok ? {1'b1, 26'd0, top} : 32'd0;
            2'd3: rdata = 32'(in_service_q);
            default: rdata = '0;
        endcase
    end

    assign data_bus = rd_hit ? rdata : 'z;

    // Reads complete in the strobe cycle; writes acknowledge from the next cycle.
    assign fc_val  = idle ? rd_bus : (rd_bus || wr_bus);
    assign fc_bus  = hit ? fc_val : 1'bz;
    assign irq_out = irq_q;

    // ---------------- Next-state register values ----------------
    assign en_merged = (32'(enable_q) & ~byte_mask) | (wdata & byte_mask);

    always_comb begin
        enable_d    = enable_q;
        pending_clr = '0;
        claim_set   = '0;
        svc_clr     = '0;
        if (idle && rd_hit && (widx == 2'd2) && claim_ok) begin
            claim_set = N_SOURCES'(1) << top;
        end
        if (idle && wr_hit) begin
            unique case (widx)
                2'd0: enable_d = en_merged[N_SOURCES-1:0];
                2'd1: pending_clr = wdata[N_SOURCES-1:0] & byte_mask[N_SOURCES-1:0];
                2'd3: begin
                    if (32'(wdata[4:0]) < N_SOURCES) svc_clr = N_SOURCES'(1) << wdata[4:0];
                end
                default: ;
            endcase
        end
        // A new edge always wins over a clear or a claim of the same bit.
        pending_d    = (pending_q & ~pending_clr & ~claim_set) | rise;
        in_service_d = (in_service_q | claim_set) & ~svc_clr;
    end

    // ---------------- State ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            enable_q     <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            prev_irq_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            prev_irq_q   <= irq_in;
            irq_q        <= irq_d;
            unique case (state_q)
                StIdle: if (rd_hit || wr_hit) state_q <= StDone;
                StDone: if (!rd_bus && !wr_bus) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (8 sources, base 0x1000).
module tb_interrupt_controller;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_EN   = BASE + 32'd0;
    localparam logic [31:0] A_PEND = BASE + 32'd4;
    localparam logic [31:0] A_CLM  = BASE + 32'd8;
    localparam logic [31:0] A_COMP = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        irq_out;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus, wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;
    logic [31:0] tb_wdata;
    logic        tb_drive;
    logic [31:0] rd_val;

    int n_vec  = 0;
    int n_fail = 0;

    assign data_bus = tb_drive ? tb_wdata : 32'bz;

    interrupt_controller #(
        .START_ADDR(BASE),
        .N_SOURCES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .irq_out      (irq_out),
        .addr_bus     (addr_bus),
        .data_bus     (data_bus),
        .rd_bus       (rd_bus),
        .wr_bus       (wr_bus),
        .data_mask_bus(data_mask_bus),
        .fc_bus       (fc_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        addr_bus = addr;
        rd_bus   = 1'b1;
        #1;
        data = data_bus;
        check("fc_read", 32'(fc_bus), 32'd1);
        tick();
        rd_bus = 1'b0;
        tick();
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask);
        addr_bus      = addr;
        tb_wdata      = data;
        tb_drive      = 1'b1;
        data_mask_bus = mask;
        wr_bus        = 1'b1;
        #1;
        check("fc_write_first", 32'(fc_bus), 32'd0);
        tick();
        check("fc_write_held", 32'(fc_bus), 32'd1);
        wr_bus   = 1'b0;
        tb_drive = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq_in = lines;
        tick();
        irq_in = 8'h00;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        irq_in = '0; addr_bus = '0; rd_bus = 0; wr_bus = 0;
        data_mask_bus = 4'hF; tb_wdata = '0; tb_drive = 0;
        do_reset();

        // Reset state
        check("irq_out_reset", 32'(irq_out), 32'd0);
        read_check("enable_reset", A_EN, 32'h0);
        read_check("pending_reset", A_PEND, 32'h0);
        read_check("claim_empty", A_CLM, 32'h0);
        read_check("in_service_reset", A_COMP, 32'h0);

        // Basic capture, priority and claim
        bus_write(A_EN, 32'h05, 4'hF);
        pulse(8'h04);
        pulse(8'h01);
        read_check("pending_05", A_PEND, 32'h05);
        check("irq_out_pending", 32'(irq_out), 32'd1);
        read_check("claim_src0", A_CLM, 32'h8000_0000);
        read_check("pending_after_claim", A_PEND, 32'h04);
        read_check("in_service_src0", A_COMP, 32'h01);
        check("irq_out_in_service", 32'(irq_out), 32'd0);
`ifndef INTC_NESTING_EN
        read_check("claim_blocked", A_CLM, 32'h0);
        read_check("pending_unchanged", A_PEND, 32'h04);
`endif
        bus_write(A_COMP, 32'd0, 4'hF);
        check("irq_out_after_complete", 32'(irq_out), 32'd1);
        read_check("claim_src2", A_CLM, 32'h8000_0002);
        bus_write(A_COMP, 32'd2, 4'hF);
        read_check("in_service_clear", A_COMP, 32'h0);

        // Held CLAIM read claims only once
        bus_write(A_EN, 32'hFF, 4'hF);
        pulse(8'h06);
        addr_bus = A_CLM;
        rd_bus   = 1'b1;
        #1;
        check("held_claim_data", data_bus, 32'h8000_0001);
        check("held_fc_0", 32'(fc_bus), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_fc", 32'(fc_bus), 32'd1);
        end
        rd_bus = 1'b0;
        tick();
        read_check("held_pending", A_PEND, 32'h04);
        read_check("held_in_service", A_COMP, 32'h02);
        bus_write(A_COMP, 32'd1, 4'hF);

        // Rise and W1C of the same bit in the same cycle: rise wins
        addr_bus = A_PEND; tb_wdata = 32'h08; tb_drive = 1; data_mask_bus = 4'hF;
        wr_bus = 1'b1; irq_in = 8'h08;
        tick();
        wr_bus = 1'b0; tb_drive = 0;
        tick();
        read_check("rise_beats_w1c", A_PEND, 32'h0C);
        bus_write(A_PEND, 32'h0C, 4'hF);
        read_check("w1c_clear", A_PEND, 32'h00);
        irq_in = 8'h00;
        tick();

        // Rise and CLAIM of the same bit: bit re-pends
        pulse(8'h20);
        addr_bus = A_CLM; rd_bus = 1'b1; irq_in = 8'h20;
        #1;
        check("claim_src5", data_bus, 32'h8000_0005);
        tick();
        rd_bus = 1'b0; irq_in = 8'h00;
        tick();
        read_check("repend_pending", A_PEND, 32'h20);
        read_check("repend_in_service", A_COMP, 32'h20);
        check("irq_out_self_in_service", 32'(irq_out), 32'd0);
        bus_write(A_COMP, 32'd9, 4'hF);
        read_check("complete_out_of_range", A_COMP, 32'h20);
        bus_write(A_COMP, 32'd5, 4'hF);
        check("irq_out_repend_delivered", 32'(irq_out), 32'd1);

        // Disabling hides the source but keeps the pending bit
        bus_write(A_EN, 32'h00, 4'hF);
        check("irq_out_disabled", 32'(irq_out), 32'd0);
        read_check("pending_kept", A_PEND, 32'h20);
        read_check("claim_disabled", A_CLM, 32'h0);

        // Byte-masked ENABLE and PENDING writes
        bus_write(A_EN, 32'hFFFF_FFFF, 4'b0001);
        read_check("enable_lane0", A_EN, 32'h0000_00FF);
        bus_write(A_EN, 32'h0, 4'b0010);
        read_check("enable_lane1", A_EN, 32'h0000_00FF);
        bus_write(A_PEND, 32'hFFFF_FFFF, 4'b1110);
        read_check("w1c_masked", A_PEND, 32'h20);
        bus_write(A_PEND, 32'h20, 4'b0001);
        read_check("w1c_lane0", A_PEND, 32'h00);

        // Reset in the middle of a held write
        addr_bus = A_EN; tb_wdata = 32'h01; tb_drive = 1; data_mask_bus = 4'hF;
        wr_bus = 1'b1;
        tick();
        check("fc_before_rst", 32'(fc_bus), 32'd1);
        rst = 1'b1;
        tick();
        check("fc_after_rst", 32'(fc_bus), 32'd0);
        check("irq_out_after_rst", 32'(irq_out), 32'd0);
        wr_bus = 1'b0; tb_drive = 0; rst = 1'b0;
        tick();
        read_check("enable_after_rst", A_EN, 32'h0);

        // Nesting behaviour
        do_reset();
        bus_write(A_EN, 32'hFF, 4'hF);
        pulse(8'h10);
        read_check("claim_src4", A_CLM, 32'h8000_0004);
        pulse(8'h02);
`ifdef INTC_NESTING_EN
        check("nest_irq_preempt", 32'(irq_out), 32'd1);
        read_check("nest_claim_src1", A_CLM, 32'h8000_0001);
        read_check("nest_in_service", A_COMP, 32'h12);
`else
        check("nest_irq_blocked", 32'(irq_out), 32'd0);
        read_check("nest_claim_blocked", A_CLM, 32'h0);
        read_check("nest_in_service", A_COMP, 32'h10);
`endif
        pulse(8'h40);
        check("nest_lower_prio", 32'(irq_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
